blink_rate_select: RTL and testbench
====================================

Name: blink_rate_select

Overview:
- Upstream stage of the LED blinker.
- Synchronises and debounces a raw active-low pushbutton.
- Each debounced press steps through a fixed table of blink rates.
- Drives the blinker's 25-bit toggle-delay value (terminal count), so one button cycles 1/2/4/8 blinks per second.

Parameters:
- DEB_CYCLES, 500_000, consecutive stable cycles needed to accept a new button level (10 ms at 50 MHz); legal range ≥2; benches use 4.
- RESET_IDX, 1, rate index loaded at reset (0..3).

Ports:
- CLK50  in  1  50 MHz system clock.
- RST_N  in  1  asynchronous active-low reset.
- BTN_N  in  1  raw pushbutton, active-low, asynchronous to CLK50, bouncy.
- DELAY  out  25  blinker terminal count for the current rate (registered).
- RATE_IDX  out  2  current rate index (registered).
- PRESS  out  1  one-cycle pulse on each accepted press.
- BTN_LEVEL  out  1  debounced button state, 1 = pressed.

Behaviour:
- Rate table, index → DELAY:
  - 0 → 24_999_999 (1 blink/s)
  - 1 → 12_499_999 (2/s)
  - 2 → 6_249_999 (4/s)
  - 3 → 3_124_999 (8/s)
- Reset (RST_N low, async, any cycle, including mid-debounce):
  - sync flops = 1 (released); debounced level = released; debounce counter = 0.
  - BTN_LEVEL = 0, PRESS = 0, RATE_IDX = RESET_IDX, DELAY = table[RESET_IDX].
- Synchroniser: two flops, s1 then s2. BTN_N is sampled only through s1.
- Debounce counter, width = clog2(DEB_CYCLES):
  - If s2 equals the debounced level, the counter clears to 0.
  - Otherwise it increments.
  - When it is at DEB_CYCLES-1 and s2 still differs, the debounced level takes s2 and the counter clears to 0.
- Accept timing: a level change is accepted only after DEB_CYCLES consecutive differing s2 samples. Any shorter excursion leaves no trace.
- Latency: let edge 1 be the first edge at which s1 samples the new BTN_N value, with the value held. BTN_LEVEL changes at edge DEB_CYCLES+2.
- Press event (debounced level goes released→pressed), at that same edge:
  - PRESS = 1 for exactly one cycle.
  - RATE_IDX increments; 3 wraps to 0.
- DELAY is registered from RATE_IDX and updates one edge after RATE_IDX.
- Release (pressed→released): BTN_LEVEL falls, no PRESS, RATE_IDX unchanged.
- Held button: exactly one PRESS per press, regardless of hold duration.
- Bounce: toggling within the window keeps clearing the counter. Exactly one PRESS once the level is stable for DEB_CYCLES.
- Back-to-back presses: each needs a full accepted release in between.
- DELAY is always one of the four table values. It never takes an intermediate value, and it changes only on the edge after a RATE_IDX change.

Decomposition:
- Package blinky_pkg holds:
  - DELAY_W = 25
  - RATE_IDX_W = 2
  - the 4-entry rate table constants
  - CLK_HZ = 50_000_000
- Sub-module btn_debounce (parameter DEB_CYCLES): synchroniser plus debounce counter. Outputs the debounced level and a one-cycle press strobe.
- The top level holds the index counter and table lookup register.

Test Plan (DEB_CYCLES=4, RESET_IDX=1 unless noted):
1. Reset: RST_N low with BTN_N=1, then high → DELAY=12_499_999, RATE_IDX=1, BTN_LEVEL=0, PRESS=0. Repeat with RESET_IDX=3 → DELAY=3_124_999.
2. Single press, BTN_N low 20 cycles then high 20:
   - edge 6: PRESS=1 for one cycle, RATE_IDX=2, BTN_LEVEL=1.
   - edge 7: DELAY=6_249_999.
   - on release, BTN_LEVEL=0 after 6 edges; RATE_IDX stays 2; no further PRESS.
3. Glitch: BTN_N low 3 cycles then high → BTN_LEVEL, PRESS and RATE_IDX never change.
4. Wrap: three clean presses from idx 1 → RATE_IDX 2, 3, 0. Final DELAY=24_999_999, and exactly 3 PRESS pulses.
5. Bounce: BTN_N toggles every 2 cycles for 12 cycles, then stays low 10 → exactly one PRESS, RATE_IDX=2.
6. Reset mid-debounce: BTN_N low for 3 cycles, assert RST_N, release RST_N, keep BTN_N low:
   - no PRESS before reset; RATE_IDX=1 after reset.
   - PRESS arrives 6 edges after reset release (full count restarts).

Source files
------------

// File: rtl/blinky_pkg.sv
// Shared types and constants for the LED blinker front end.
// Latency: n/a (constants and a pure lookup function only).
// Backpressure: n/a.
//
// Contents: delay/index widths, system clock rate, the four-entry
// blink-rate table and a lookup helper used by blink_rate_select.
package blinky_pkg;

   localparam int DELAY_W    = 25;
   localparam int RATE_IDX_W = 2;
   localparam int CLK_HZ     = 50_000_000;

   typedef logic [DELAY_W-1:0]    delay_t;
   typedef logic [RATE_IDX_W-1:0] rate_idx_t;

   // The blinker toggles its LED each time its counter reaches the terminal
   // count, so one full blink is two toggles.  The count is therefore
   // CLK_HZ / (2 * blinks_per_second) - 1.
   localparam delay_t RATE_DELAY_1HZ = delay_t'(CLK_HZ / 2  - 1);  // 24_999_999
   localparam delay_t RATE_DELAY_2HZ = delay_t'(CLK_HZ / 4  - 1);  // 12_499_999
   localparam delay_t RATE_DELAY_4HZ = delay_t'(CLK_HZ / 8  - 1);  //  6_249_999
   localparam delay_t RATE_DELAY_8HZ = delay_t'(CLK_HZ / 16 - 1);  //  3_124_999

   localparam rate_idx_t RATE_IDX_LAST = rate_idx_t'(3);

   // Table lookup: index -> terminal count.
   function automatic delay_t rate_delay(input rate_idx_t idx);
      delay_t d;
      case (idx)
         2'd0:    d = RATE_DELAY_1HZ;
         2'd1:    d = RATE_DELAY_2HZ;
         2'd2:    d = RATE_DELAY_4HZ;
         default: d = RATE_DELAY_8HZ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counter debouncer for an active-low pushbutton.
// Latency: new level accepted DEB_CYCLES+2 edges after s1 first samples it.
// Backpressure: none; the press strobe is a fire-and-forget pulse.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   btn_n_i      raw button, active-low, asynchronous, bouncy
//   level_o      debounced level, 1 = pressed (registered)
//   press_o      one-cycle pulse on each released->pressed acceptance (registered)
//   press_nxt_o  combinational: press_o will be 1 after the coming edge; lets the
//                parent update state on the same edge that press_o rises
module btn_debounce
   import blinky_pkg::*;
#(
   parameter int DEB_CYCLES = 500_000
)(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_n_i,
   output logic level_o,
   output logic press_o,
   output logic press_nxt_o
);

   localparam int                CNT_W    = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   // Synchroniser stages, held at the released level (1) in reset.
   logic             sync1_q;
   logic             sync2_q;

   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;

   // Synchronised sample in pressed-sense so it can be compared to level_q.
   logic             s2_pressed;
   assign s2_pressed = ~sync2_q;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (s2_pressed == level_q) begin
         // Any sample agreeing with the current level restarts the window,
         // so bounces and short glitches leave no trace.
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // This is the DEB_CYCLES-th consecutive differing sample.
         level_d = s2_pressed;
         cnt_d   = '0;
         press_d = s2_pressed;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level_o     = level_q;
   assign press_o     = press_q;
   assign press_nxt_o = press_d;

endmodule

// File: rtl/blink_rate_select.sv
// Button-driven blink-rate selector feeding the blinker's terminal count.
// Latency: RATE_IDX on the press-accept edge, DELAY one edge later.
// Backpressure: none; every accepted press advances the rate unconditionally.
//
// Ports:
//   CLK50      50 MHz system clock
//   RST_N      asynchronous active-low reset
//   BTN_N      raw pushbutton, active-low, asynchronous, bouncy
//   DELAY      blinker terminal count for the current rate (registered)
//   RATE_IDX   current rate index 0..3 (registered)
//   PRESS      one-cycle pulse per accepted press
//   BTN_LEVEL  debounced button level, 1 = pressed
module blink_rate_select
   import blinky_pkg::*;
#(
   parameter int DEB_CYCLES = 500_000,
   parameter int RESET_IDX  = 1
)(
   input  logic                  CLK50,
   input  logic                  RST_N,
   input  logic                  BTN_N,
   output logic [DELAY_W-1:0]    DELAY,
   output logic [RATE_IDX_W-1:0] RATE_IDX,
   output logic                  PRESS,
   output logic                  BTN_LEVEL
);

   localparam rate_idx_t RESET_IDX_V = rate_idx_t'(RESET_IDX);

   logic      press_nxt;
   logic      deb_level;
   logic      deb_press;

   rate_idx_t rate_idx_q, rate_idx_d;
   delay_t    delay_q,    delay_d;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn_debounce (
      .clk_i       (CLK50),
      .rst_n_i     (RST_N),
      .btn_n_i     (BTN_N),
      .level_o     (deb_level),
      .press_o     (deb_press),
      .press_nxt_o (press_nxt)
   );

   // The index advances on the same edge the press strobe rises, so it keys
   // off the debouncer's next-state strobe rather than the registered one.
   always_comb begin
      rate_idx_d = rate_idx_q;
      if (press_nxt) begin
         rate_idx_d = (rate_idx_q == RATE_IDX_LAST) ? '0 : rate_idx_q + rate_idx_t'(1);
      end
   end

   // Lookup from the registered index: DELAY trails RATE_IDX by one edge and
   // is always a whole table entry, never a mix of old and new.
   assign delay_d = rate_delay(rate_idx_q);

   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         rate_idx_q <= RESET_IDX_V;
         delay_q    <= rate_delay(RESET_IDX_V);
      end else begin
         rate_idx_q <= rate_idx_d;
         delay_q    <= delay_d;
      end
   end

   assign DELAY     = delay_q;
   assign RATE_IDX  = rate_idx_q;
   assign PRESS     = deb_press;
   assign BTN_LEVEL = deb_level;

endmodule

// File: tb/tb_blink_rate_select.sv
// Self-checking bench for blink_rate_select with DEB_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_blink_rate_select;

   localparam int DEB = 4;

   logic        CLK50 = 1'b0;
   logic        RST_N = 1'b0;
   logic        BTN_N = 1'b1;

   logic [24:0] DELAY,  DELAY3;
   logic [1:0]  RATE_IDX, RATE_IDX3;
   logic        PRESS,  PRESS3;
   logic        BTN_LEVEL, BTN_LEVEL3;

   int errors = 0;
   int checks = 0;
   int press_cnt = 0;

   always #10 CLK50 = ~CLK50;

   blink_rate_select #(.DEB_CYCLES(DEB), .RESET_IDX(1)) dut (
      .CLK50     (CLK50),
      .RST_N     (RST_N),
      .BTN_N     (BTN_N),
      .DELAY     (DELAY),
      .RATE_IDX  (RATE_IDX),
      .PRESS     (PRESS),
      .BTN_LEVEL (BTN_LEVEL)
   );

   blink_rate_select #(.DEB_CYCLES(DEB), .RESET_IDX(3)) dut3 (
      .CLK50     (CLK50),
      .RST_N     (RST_N),
      .BTN_N     (BTN_N),
      .DELAY     (DELAY3),
      .RATE_IDX  (RATE_IDX3),
      .PRESS     (PRESS3),
      .BTN_LEVEL (BTN_LEVEL3)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Blinks per second = 2^idx; terminal count = half a blink period minus one.
   function automatic int tbl(input int i);
      return (50_000_000 / (2 << i)) - 1;
   endfunction

   // Raw BTN_N samples; the debouncer judges the sample taken two edges earlier.
   logic mq[$];
   int   m_run;
   bit   m_lvl;
   bit   m_press;
   int   m_idx;
   int   m_delay;

   always @(posedge CLK50 or negedge RST_N) begin : model
      bit judged;
      if (!RST_N) begin
         mq      = '{1'b1, 1'b1};
         m_run   = 0;
         m_lvl   = 1'b0;
         m_press = 1'b0;
         m_idx   = 1;
         m_delay = tbl(1);
      end else begin
         judged = !mq[0];
         void'(mq.pop_front());
         mq.push_back(BTN_N);
         m_press = 1'b0;
         m_delay = tbl(m_idx);
         if (judged != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
               m_lvl = judged;
               m_run = 0;
               if (judged) begin
                  m_press = 1'b1;
                  m_idx   = (m_idx + 1) % 4;
               end
            end
         end else begin
            m_run = 0;
         end
      end
   end

   always @(negedge CLK50) begin
      chk("mdl_level", BTN_LEVEL, m_lvl);
      chk("mdl_press", PRESS,     m_press);
      chk("mdl_idx",   RATE_IDX,  m_idx);
      chk("mdl_delay", DELAY,     m_delay);
      if (PRESS) press_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   // Hold BTN_N at v across n rising edges; returns on a falling edge.
   task automatic drive(input bit v, input int n);
      BTN_N = v;
      repeat (n) @(negedge CLK50);
   endtask

   // Pulse reset from mid-low-phase; returns just after release.
   task automatic do_reset();
      #2 RST_N = 1'b0;
      repeat (2) @(negedge CLK50);
      #2 RST_N = 1'b1;
   endtask

   int p0;
   int exp_idx[3] = '{2, 3, 0};

   initial begin
      // 1. Reset values, both RESET_IDX variants
      repeat (2) @(negedge CLK50);
      chk("rst_in_delay", DELAY,     12_499_999);
      chk("rst_in_level", BTN_LEVEL, 0);
      #2 RST_N = 1'b1;
      repeat (3) @(negedge CLK50);
      chk("rst_delay",  DELAY,     12_499_999);
      chk("rst_idx",    RATE_IDX,  1);
      chk("rst_level",  BTN_LEVEL, 0);
      chk("rst_press",  PRESS,     0);
      chk("rst3_delay", DELAY3,    3_124_999);
      chk("rst3_idx",   RATE_IDX3, 3);

      // 2. Single press: accept at edge 6, DELAY at edge 7
      p0 = press_cnt;
      BTN_N = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(negedge CLK50);
         if (e == 5) begin
            chk("p2_e5_press", PRESS,     0);
            chk("p2_e5_level", BTN_LEVEL, 0);
         end
         if (e == 6) begin
            chk("p2_e6_press", PRESS,     1);
            chk("p2_e6_idx",   RATE_IDX,  2);
            chk("p2_e6_level", BTN_LEVEL, 1);
            chk("p2_e6_delay", DELAY,     12_499_999);
         end
         if (e == 7) begin
            chk("p2_e7_press", PRESS, 0);
            chk("p2_e7_delay", DELAY, 6_249_999);
         end
      end
      repeat (13) @(negedge CLK50);
      BTN_N = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(negedge CLK50);
         if (e == 5) chk("p2_rel_e5_level", BTN_LEVEL, 1);
         if (e == 6) chk("p2_rel_e6_level", BTN_LEVEL, 0);
      end
      repeat (14) @(negedge CLK50);
      chk("p2_idx_after",  RATE_IDX,       2);
      chk("p2_press_cnt",  press_cnt - p0, 1);
      chk("p2_3_idx",      RATE_IDX3,      0);
      chk("p2_3_delay",    DELAY3,         24_999_999);

      // 3. Glitch shorter than the window
      p0 = press_cnt;
      drive(1'b0, 3);
      drive(1'b1, 12);
      chk("glitch_idx",   RATE_IDX,       2);
      chk("glitch_press", press_cnt - p0, 0);
      chk("glitch_level", BTN_LEVEL,      0);

      // 4. Wrap through the table from index 1
      do_reset();
      p0 = press_cnt;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 10);
         chk("wrap_idx", RATE_IDX, exp_idx[k]);
         drive(1'b1, 10);
      end
      chk("wrap_final_idx",   RATE_IDX,       0);
      chk("wrap_final_delay", DELAY,          24_999_999);
      chk("wrap_press_cnt",   press_cnt - p0, 3);

      // 5. Bouncy press then a clean release
      do_reset();
      p0 = press_cnt;
      for (int k = 0; k < 6; k++) drive((k % 2) != 0, 2);
      drive(1'b0, 10);
      chk("bounce_press_cnt", press_cnt - p0, 1);
      chk("bounce_idx",       RATE_IDX,       2);
      drive(1'b1, 10);
      chk("bounce_rel_cnt",   press_cnt - p0, 1);
      chk("bounce_rel_level", BTN_LEVEL,      0);

      // 6. Reset mid-debounce restarts the full count
      do_reset();
      p0 = press_cnt;
      drive(1'b0, 3);
      chk("mid_no_press", press_cnt - p0, 0);
      #2 RST_N = 1'b0;
      repeat (2) @(negedge CLK50);
      chk("mid_rst_idx", RATE_IDX, 1);
      #2 RST_N = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(negedge CLK50);
         if (e == 5) chk("mid_e5_press", PRESS, 0);
         if (e == 6) begin
            chk("mid_e6_press", PRESS,    1);
            chk("mid_e6_idx",   RATE_IDX, 2);
         end
      end
      drive(1'b1, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
